rv32i_multicycle_ctrl: RTL and testbench
========================================

Name: rv32i_multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I core.
- Sequences each instruction through fetch, decode, execute, memory and writeback, and drives the datapath selects: PC, IR, register file, ALU operand/op, immediate consumer, memory port.
- Implements a req/ready handshake to the shared instruction/data memory port.
- Detects illegal opcodes and memory timeouts, and counts retired instructions.

Parameters:
- MEM_TIMEOUT, 255: max wait cycles for mem_ready per transfer; 0 disables the timeout.
- CNT_W, 32: width of the instret counter.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr  in  32  current IR contents (opcode = instr[6:0])
- branch_taken  in  1  ALU comparison result, valid in EXEC for BRANCH
- mem_ready  in  1  memory port completes the transfer this cycle
- mem_req  out  1  memory request
- mem_we  out  1  1 = store, 0 = read
- addr_sel  out  1  0 = PC, 1 = ALU result
- ir_we  out  1  load IR from memory read data
- pc_we  out  1  update PC
- pc_sel  out  2  00 = PC+4, 01 = PC+imm, 10 = ALU result with bit0 cleared
- rf_we  out  1  register file write
- wb_sel  out  2  00 = ALU, 01 = memory data, 10 = PC+4
- alu_a_sel  out  1  0 = rs1, 1 = PC
- alu_b_sel  out  1  0 = rs2, 1 = imm
- alu_op  out  2  00 = add, 01 = funct3/funct7 decoded, 10 = branch compare, 11 = pass B
- trap  out  1  sticky fault flag
- trap_cause  out  2  01 = illegal opcode, 10 = memory timeout
- instret  out  CNT_W  retired-instruction count

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Reset (async, rst_n = 0): state = FETCH; instret = 0; trap = 0; trap_cause = 00; timeout counter = 0; opcode class register cleared.
- All control outputs are combinational from state and the latched opcode class. Every output not listed for the current state is 0.
- Reset asserted mid-transfer drops mem_req immediately.
- FETCH:
  - mem_req = 1, mem_we = 0, addr_sel = 0.
  - On mem_ready: ir_we = 1 for that cycle, then go to DECODE.
- DECODE:
  - Latch opcode class from instr[6:0]: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011.
  - Any other opcode: go to TRAP with cause 01.
  - Otherwise go to EXEC.
- EXEC, per class:
  - OP: a = rs1, b = rs2, alu_op = 01; go to WB.
  - OP-IMM: a = rs1, b = imm, alu_op = 01; go to WB.
  - LOAD/STORE: a = rs1, b = imm, alu_op = 00; go to MEM.
  - LUI: b = imm, alu_op = 11; go to WB.
  - AUIPC: a = PC, b = imm, alu_op = 00; go to WB.
  - JAL/JALR: a = rs1, b = imm, alu_op = 00; go to WB.
  - BRANCH: a = rs1, b = rs2, alu_op = 10; pc_we = 1; pc_sel = branch_taken ? 01 : 00; retire; go to FETCH.
- MEM:
  - mem_req = 1, addr_sel = 1, mem_we = 1 for STORE.
  - The ALU result is held in a datapath register.
  - On mem_ready, STORE: pc_we = 1, pc_sel = 00, retire, go to FETCH.
  - On mem_ready, LOAD: go to WB.
- WB:
  - rf_we = 1.
  - wb_sel: 01 for LOAD, 10 for JAL/JALR, 00 otherwise.
  - pc_we = 1; pc_sel: 01 for JAL, 10 for JALR, 00 otherwise.
  - Retire; go to FETCH.
- Handshake:
  - A transfer completes on the cycle with mem_req && mem_ready.
  - While waiting, mem_req, mem_we and addr_sel stay stable.
  - mem_ready is ignored when mem_req = 0.
- Timeout:
  - The counter clears on entry to FETCH or MEM and increments each cycle with mem_req && !mem_ready.
  - When MEM_TIMEOUT != 0 and the counter reaches MEM_TIMEOUT with ready still low: go to TRAP with cause 10; mem_req drops the next cycle.
  - mem_ready arriving in the same cycle the limit is hit counts as success.
- TRAP:
  - trap = 1, trap_cause held, all strobes 0.
  - Exit only via reset.
- Retirement:
  - instret += 1 on every transition into FETCH from EXEC, MEM or WB.
  - Wraps modulo 2^CNT_W.
  - Not incremented on a trapped instruction.
- Latency with mem_ready tied high:
  - BRANCH: 3 cycles.
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR: 4 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.

Test Plan:
- Reset then addi x1,x0,5 (0x00500093) with mem_ready = 1 → states FETCH→DECODE→EXEC→WB; WB has rf_we = 1, wb_sel = 00, pc_sel = 00; instret = 1 after 4 cycles.
- lw (0x0000A103) with mem_ready delayed 3 cycles in MEM → mem_req and addr_sel = 1 held 4 cycles, then WB with wb_sel = 01; total 8 cycles.
- beq (0x00208463): branch_taken = 1 gives pc_sel = 01 in EXEC; branch_taken = 0 gives pc_sel = 00; 3 cycles each; no rf_we.
- jalr (0x000080E7) → WB has wb_sel = 10, pc_sel = 10, rf_we = 1.
- instr = 0xFFFFFFFF → TRAP after DECODE; trap = 1, cause 01; no strobes; instret unchanged until rst_n pulse, then FETCH.
- MEM_TIMEOUT = 4, mem_ready = 0 in FETCH → TRAP with cause 10 after 4 wait cycles; rst_n = 0 mid-wait instead drops mem_req asynchronously.

Source files
------------

// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing,
// datapath select generation, memory req/ready handshake, fault trapping and instret.
module rv32i_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             alu_a_sel,
    output logic             alu_b_sel,
    output logic [1:0]       alu_op,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_NONE, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH, C_LOAD, C_STORE, C_OPIMM, C_OP
    } cls_t;

    // Counter only needs to reach MEM_TIMEOUT-1; the trap fires on the wait cycle after that.
    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t        state, state_next;
    cls_t          cls, dec_cls;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic          retire;
    logic [1:0]    cause_next;
    logic          unused_instr_bits;

    assign unused_instr_bits = ^instr[31:7];
    assign state_dbg         = state;
    assign tmo_hit           = (MEM_TIMEOUT != 0) && (tmo_cnt == TMO_LAST);

    function automatic cls_t decode_op(input logic [6:0] op);
        case (op)
            7'b0110111: return C_LUI;
            7'b0010111: return C_AUIPC;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            7'b1100011: return C_BRANCH;
            7'b0000011: return C_LOAD;
            7'b0100011: return C_STORE;
            7'b0010011: return C_OPIMM;
            7'b0110011: return C_OP;
            default:    return C_NONE;
        endcase
    endfunction

    assign dec_cls = decode_op(instr[6:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            cls        <= C_NONE;
            trap_cause <= 2'b00;
            instret    <= '0;
            tmo_cnt    <= '0;
        end else begin
            state <= state_next;
            if (state == DECODE)
                cls <= dec_cls;
            if (state_next == TRAP && state != TRAP)
                trap_cause <= cause_next;
            if (retire)
                instret <= instret + CNT_W'(1);
            if ((state_next == FETCH || state_next == MEM) && state_next != state)
                tmo_cnt <= '0;
            else if (mem_req && !mem_ready)
                tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    always_comb begin
        state_next = state;
        cause_next = 2'b00;
        retire     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = 2'b00;
        rf_we      = 1'b0;
        wb_sel     = 2'b00;
        alu_a_sel  = 1'b0;
        alu_b_sel  = 1'b0;
        alu_op     = 2'b00;
        trap       = 1'b0;

        case (state)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we      = 1'b1;
                    state_next = DECODE;
                end else if (tmo_hit) begin
                    state_next = TRAP;
                    cause_next = 2'b10;
                end
            end
            DECODE: begin
                if (dec_cls == C_NONE) begin
                    state_next = TRAP;
                    cause_next = 2'b01;
                end else begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                case (cls)
                    C_OP: begin
                        alu_op     = 2'b01;
                        state_next = WB;
                    end
                    C_OPIMM: begin
                        alu_b_sel  = 1'b1;
                        alu_op     = 2'b01;
                        state_next = WB;
                    end
                    C_LOAD, C_STORE: begin
                        alu_b_sel  = 1'b1;
                        state_next = MEM;
                    end
                    C_LUI: begin
                        alu_b_sel  = 1'b1;
                        alu_op     = 2'b11;
                        state_next = WB;
                    end
                    C_AUIPC: begin
                        alu_a_sel  = 1'b1;
                        alu_b_sel  = 1'b1;
                        state_next = WB;
                    end
                    C_JAL, C_JALR: begin
                        alu_b_sel  = 1'b1;
                        state_next = WB;
                    end
                    C_BRANCH: begin
                        alu_op     = 2'b10;
                        pc_we      = 1'b1;
                        pc_sel     = branch_taken ? 2'b01 : 2'b00;
                        retire     = 1'b1;
                        state_next = FETCH;
                    end
                    default: begin
                        state_next = TRAP;
                        cause_next = 2'b01;
                    end
                endcase
            end
            MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (cls == C_STORE);
                if (mem_ready) begin
                    if (cls == C_STORE) begin
                        pc_we      = 1'b1;
                        retire     = 1'b1;
                        state_next = FETCH;
                    end else begin
                        state_next = WB;
                    end
                end else if (tmo_hit) begin
                    state_next = TRAP;
                    cause_next = 2'b10;
                end
            end
            WB: begin
                rf_we      = 1'b1;
                pc_we      = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
                if (cls == C_LOAD)
                    wb_sel = 2'b01;
                else if (cls == C_JAL || cls == C_JALR)
                    wb_sel = 2'b10;
                if (cls == C_JAL)
                    pc_sel = 2'b01;
                else if (cls == C_JALR)
                    pc_sel = 2'b10;
            end
            TRAP: begin
                trap = 1'b1;
            end
            default: begin
                state_next = FETCH;
            end
        endcase

        // The state register sits in FETCH during reset; keep the memory port quiet.
        if (!rst_n) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            ir_we   = 1'b0;
        end
    end

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Bench for rv32i_multicycle_ctrl: per-cycle expected control words from a vector table
// and hand-built sequences go into a scoreboard queue and are compared each cycle.
module tb_rv32i_multicycle_ctrl;

  localparam int CNT_W = 3;
  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                         S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0]      instr = 32'h0;
  logic             branch_taken = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_req, mem_we, addr_sel, ir_we, pc_we, rf_we;
  logic [1:0]       pc_sel, wb_sel, alu_op, trap_cause;
  logic             alu_a_sel, alu_b_sel, trap;
  logic [CNT_W-1:0] instret;
  logic [2:0]       state_dbg;
  logic [19:0]      act_w;

  always #5 clk = ~clk;

  rv32i_multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op), .trap(trap),
    .trap_cause(trap_cause), .instret(instret), .state_dbg(state_dbg)
  );

  assign act_w = {state_dbg, mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, rf_we,
                  wb_sel, alu_a_sel, alu_b_sel, alu_op, trap, trap_cause};

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        bt;
    logic        has_mem;
    logic        is_store;
    logic        has_wb;
    logic        ex_a;
    logic        ex_b;
    logic [1:0]  ex_op;
    logic        ex_pcwe;
    logic [1:0]  ex_pcsel;
    logic [1:0]  wb_sel;
    logic [1:0]  wb_pcsel;
  } vec_t;

  vec_t             vecs[10];
  logic [19:0]      exp_q[$];
  string            tag_q[$];
  logic [CNT_W-1:0] exp_ret = '0;
  int               checks = 0;
  int               errors = 0;

  function automatic logic [19:0] mk(input logic [2:0] st, input logic req, input logic we,
      input logic asel, input logic irwe, input logic pcwe, input logic [1:0] pcs,
      input logic rfwe, input logic [1:0] wbs, input logic a, input logic b,
      input logic [1:0] op, input logic tr, input logic [1:0] tc);
    return {st, req, we, asel, irwe, pcwe, pcs, rfwe, wbs, a, b, op, tr, tc};
  endfunction

  function automatic vec_t mkvec(input string n, input logic [31:0] i, input logic bt,
      input logic hm, input logic st, input logic hw, input logic a, input logic b,
      input logic [1:0] op, input logic epw, input logic [1:0] eps,
      input logic [1:0] ws, input logic [1:0] wps);
    vec_t v;
    v.name = n; v.instr = i; v.bt = bt; v.has_mem = hm; v.is_store = st; v.has_wb = hw;
    v.ex_a = a; v.ex_b = b; v.ex_op = op; v.ex_pcwe = epw; v.ex_pcsel = eps;
    v.wb_sel = ws; v.wb_pcsel = wps;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input string tag, input logic [19:0] w);
    exp_q.push_back(w);
    tag_q.push_back(tag);
  endtask

  task automatic step(input logic rdy, input logic bt);
    logic [19:0] e;
    string       t;
    @(negedge clk);
    mem_ready = rdy;
    branch_taken = bt;
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: queue empty, got %h expected an entry", act_w);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, {12'h0, act_w}, {12'h0, e});
    end
  endtask

  task automatic check_ret(input string name);
    @(posedge clk);
    #1;
    check(name, {29'h0, instret}, {29'h0, exp_ret});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b0;
    branch_taken = 1'b0;
    #1;
    check("reset mem_req", {31'h0, mem_req}, 32'h0);
    check("reset word", {12'h0, act_w}, {12'h0, mk(S_FETCH,0,0,0,0,0,2'b00,0,2'b00,0,0,2'b00,0,2'b00)});
    check("reset instret", {29'h0, instret}, 32'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    exp_ret = '0;
  endtask

  function automatic logic [19:0] w_fetch(input logic rdy);
    return mk(S_FETCH,1,0,0,rdy,0,2'b00,0,2'b00,0,0,2'b00,0,2'b00);
  endfunction

  function automatic logic [19:0] w_trap(input logic [1:0] c);
    return mk(S_TRAP,0,0,0,0,0,2'b00,0,2'b00,0,0,2'b00,1,c);
  endfunction

  localparam logic [19:0] W_DECODE = {S_DECODE, 17'h0};

  task automatic run_vec(input vec_t v);
    instr = v.instr;
    push({v.name, " fetch"}, w_fetch(1'b1));
    push({v.name, " decode"}, W_DECODE);
    push({v.name, " exec"}, mk(S_EXEC,0,0,0,0,v.ex_pcwe,v.ex_pcsel,0,2'b00,
                              v.ex_a,v.ex_b,v.ex_op,0,2'b00));
    if (v.has_mem)
      push({v.name, " mem"}, mk(S_MEM,1,v.is_store,1,0,v.is_store,2'b00,0,2'b00,0,0,2'b00,0,2'b00));
    if (v.has_wb)
      push({v.name, " wb"}, mk(S_WB,0,0,0,0,1,v.wb_pcsel,1,v.wb_sel,0,0,2'b00,0,2'b00));
    while (exp_q.size() > 0)
      step(1'b1, v.bt);
    exp_ret = exp_ret + 1'b1;
    check_ret({v.name, " instret"});
  endtask

  initial begin
    //                 name       instr         bt mem st wb a  b  op     epw eps    wbs    wps
    vecs[0] = mkvec("addi",    32'h00500093, 0, 0, 0, 1, 0, 1, 2'b01, 0, 2'b00, 2'b00, 2'b00);
    vecs[1] = mkvec("add",     32'h002081B3, 0, 0, 0, 1, 0, 0, 2'b01, 0, 2'b00, 2'b00, 2'b00);
    vecs[2] = mkvec("lui",     32'h123450B7, 0, 0, 0, 1, 0, 1, 2'b11, 0, 2'b00, 2'b00, 2'b00);
    vecs[3] = mkvec("auipc",   32'h00001097, 0, 0, 0, 1, 1, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00);
    vecs[4] = mkvec("jal",     32'h008000EF, 0, 0, 0, 1, 0, 1, 2'b00, 0, 2'b00, 2'b10, 2'b01);
    vecs[5] = mkvec("jalr",    32'h000080E7, 0, 0, 0, 1, 0, 1, 2'b00, 0, 2'b00, 2'b10, 2'b10);
    vecs[6] = mkvec("lw",      32'h0000A103, 0, 1, 0, 1, 0, 1, 2'b00, 0, 2'b00, 2'b01, 2'b00);
    vecs[7] = mkvec("sw",      32'h0020A223, 0, 1, 1, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00);
    vecs[8] = mkvec("beq_t",   32'h00208463, 1, 0, 0, 0, 0, 0, 2'b10, 1, 2'b01, 2'b00, 2'b00);
    vecs[9] = mkvec("beq_nt",  32'h00208463, 0, 0, 0, 0, 0, 0, 2'b10, 1, 2'b00, 2'b00, 2'b00);

    do_reset();

    // Pass 1 retires 10 instructions, wrapping the 3-bit counter.
    foreach (vecs[i]) run_vec(vecs[i]);

    // Illegal opcode: trap after decode, strobes stay low even with mem_ready high.
    instr = 32'hFFFFFFFF;
    push("ill fetch", w_fetch(1'b1));
    push("ill decode", W_DECODE);
    for (int k = 0; k < 3; k++) push($sformatf("ill trap%0d", k), w_trap(2'b01));
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
    check("ill instret held", {29'h0, instret}, {29'h0, exp_ret});
    do_reset();

    // Pass 2 in shuffled order.
    for (int n = 0; n < 10; n++) run_vec(vecs[(n * 3) % 10]);

    // lw with 3 wait cycles in FETCH and in MEM; ready lands on the limit cycle.
    instr = 32'h0000A103;
    for (int k = 0; k < 3; k++) push($sformatf("lwd fetch wait%0d", k), w_fetch(1'b0));
    push("lwd fetch", w_fetch(1'b1));
    push("lwd decode", W_DECODE);
    push("lwd exec", mk(S_EXEC,0,0,0,0,0,2'b00,0,2'b00,0,1,2'b00,0,2'b00));
    for (int k = 0; k < 4; k++)
      push($sformatf("lwd mem%0d", k), mk(S_MEM,1,0,1,0,0,2'b00,0,2'b00,0,0,2'b00,0,2'b00));
    push("lwd wb", mk(S_WB,0,0,0,0,1,2'b00,1,2'b01,0,0,2'b00,0,2'b00));
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    exp_ret = exp_ret + 1'b1;
    check_ret("lwd instret");

    // Fetch timeout: four unanswered wait cycles, then trap with cause 10.
    instr = 32'h00500093;
    for (int k = 0; k < 4; k++) push($sformatf("tmo wait%0d", k), w_fetch(1'b0));
    push("tmo trap0", w_trap(2'b10));
    push("tmo trap1", w_trap(2'b10));
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("tmo instret held", {29'h0, instret}, {29'h0, exp_ret});
    do_reset();

    // Reset asserted mid-wait drops mem_req without a clock edge.
    push("async wait", w_fetch(1'b0));
    step(1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("async mem_req", {31'h0, mem_req}, 32'h0);
    check("async state", {29'h0, state_dbg}, {29'h0, S_FETCH});
    do_reset();
    run_vec(vecs[0]);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: %0d entries left over", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
